// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Handles load-use, branch redirects and data-memory waits with a watchdog.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             err_q, err_d;
    logic             freeze;
    logic             lu;

    assign freeze = (state_q != ERR) & dmem_req & ~dmem_ready;
    assign lu     = idex_mem_read & (idex_rd != 5'd0) &
                    ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    assign mem_timeout_err = err_q;
    assign stall_cycles    = stall_q;
    assign flush_count     = flush_q;

    // State, watchdog and saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    // Priority decode: error, freeze, branch, load-use, normal flow.
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        stall_d     = stall_q;
        flush_d     = flush_q;
        err_d       = err_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;

        if (state_q == ERR) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            err_d       = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            wait_d      = wait_q + WW'(1);
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
            // This is the last tolerated wait cycle: give up on the edge.
            if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                state_d = MEM_WAIT;
            end
        end else begin
            state_d = RUN;
            if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
            end else if (lu) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
            end
        end

        // Hold the pipe quiet and cleared while in reset.
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Small counters and short watchdog exercise saturation and timeout.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          idex_mem_read;
    logic [4:0]    idex_rd, ifid_rs1, ifid_rs2;
    logic          branch_taken, dmem_req, dmem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_flush;
    logic          idex_write, exmem_write, memwb_write;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]      ctrl_q[$];
    logic [2*CW:0]   cnt_q[$];

    bit m_err;
    int m_wait, m_stall, m_flush;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .idex_write(idex_write), .exmem_write(exmem_write),
        .memwb_write(memwb_write),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {pc_write, ifid_write, ifid_flush, idex_flush,
                idex_write, exmem_write, memwb_write};
    endfunction

    function automatic logic [2*CW:0] cnt_now();
        return {mem_timeout_err, stall_cycles, flush_count};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0;
        m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        ctrl_q.delete();
        cnt_q.delete();
        #1;
        chk("rst_ctrl", 64'(ctrl_now()), 64'(7'b0011000));
        chk("rst_cnt", 64'(cnt_now()), 64'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one cycle, predict outputs, compare combinational then registered.
    task automatic step(input bit mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit br, input bit req, input bit rdy,
                        input string tag);
        bit fz, lu;
        logic [6:0] ec;
        logic [2*CW:0] got_c;
        @(negedge clk);
        idex_mem_read = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        branch_taken = br; dmem_req = req; dmem_ready = rdy;
        fz = !m_err && req && !rdy;
        lu = mr && rd != 0 && (rd == r1 || rd == r2);
        if (m_err || fz) ec = 7'b0000000;
        else if (br)     ec = 7'b1111111;
        else if (lu)     ec = 7'b0001111;
        else             ec = 7'b1100111;
        ctrl_q.push_back(ec);
        if (!m_err) begin
            if (fz) begin
                m_wait++;
                if (m_stall < CMAX) m_stall++;
                if (m_wait == MT) m_err = 1;
            end else begin
                m_wait = 0;
                if (br) begin
                    if (m_flush < CMAX) m_flush++;
                end else if (lu) begin
                    if (m_stall < CMAX) m_stall++;
                end
            end
        end
        cnt_q.push_back({m_err, CW'(m_stall), CW'(m_flush)});
        #1;
        if (ctrl_q.size() == 0) chk({tag, "_ctrlq"}, 64'(0), 64'(1));
        else chk({tag, "_ctrl"}, 64'(ctrl_now()), 64'(ctrl_q.pop_front()));
        @(posedge clk);
        #1;
        got_c = cnt_now();
        if (cnt_q.size() == 0) chk({tag, "_cntq"}, 64'(0), 64'(1));
        else chk({tag, "_cnt"}, 64'(got_c), 64'(cnt_q.pop_front()));
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        step(1, 5, 3, 5, 0, 0, 0, "t1_lu");
        chk("t1_stall", 64'(stall_cycles), 64'(1));
        step(0, 5, 3, 5, 0, 0, 0, "t1_after");
        step(1, 0, 0, 0, 0, 0, 0, "t2_x0");
        step(1, 5, 3, 5, 1, 0, 0, "t3_brlu");
        chk("t3_flush", 64'(flush_count), 64'(1));
        chk("t3_stall", 64'(stall_cycles), 64'(1));

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, "t4_wait");
        step(0, 0, 0, 0, 0, 1, 1, "t4_rel");
        chk("t4_stall", 64'(stall_cycles), 64'(4));
        step(0, 0, 0, 0, 0, 0, 0, "t4_run");

        step(0, 0, 0, 0, 1, 1, 0, "brw_wait");
        step(0, 0, 0, 0, 1, 1, 0, "brw_wait");
        step(0, 0, 0, 0, 1, 0, 0, "brw_rel");

        for (int i = 0; i < 40; i++)
            step(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 bit'($urandom_range(0, 1)), "rnd");

        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0, 0, "t6_br");
        chk("t6_sat", 64'(flush_count), 64'(CMAX));

        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, "t5_wait");
        chk("t5_noerr", 64'(mem_timeout_err), 64'(0));
        step(0, 0, 0, 0, 1, 1, 0, "t5_edge4");
        chk("t5_err", 64'(mem_timeout_err), 64'(1));
        step(0, 0, 0, 0, 1, 1, 1, "t5_rdy");
        step(1, 5, 5, 0, 0, 0, 0, "t5_lu");
        chk("t5_sticky", 64'(mem_timeout_err), 64'(1));

        do_reset();
        chk("t5_clr", 64'(mem_timeout_err), 64'(0));
        step(0, 0, 0, 0, 0, 1, 0, "mid_wait");
        step(0, 0, 0, 0, 0, 1, 0, "mid_wait");
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, "mid_new");
        chk("mid_noerr", 64'(mem_timeout_err), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0, "mid_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
